// File: rtl/datapath_ctrl_pkg.sv
// Shared types, instruction field positions and per-state control decode for datapath_ctrl.
package datapath_ctrl_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 4;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 28;
    localparam int unsigned ALUOP_HI = 27;
    localparam int unsigned ALUOP_LO = 25;
    localparam int unsigned SHOP_HI  = 24;
    localparam int unsigned SHOP_LO  = 23;
    localparam int unsigned RN_HI    = 19;
    localparam int unsigned RN_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 12;
    localparam int unsigned RM_HI    = 3;
    localparam int unsigned RM_LO    = 0;

    // Accept edge to done cycle, in clocks
    localparam int unsigned LAT_ALU_RR = 4;
    localparam int unsigned LAT_ALU_RI = 3;
    localparam int unsigned LAT_CMP_RR = 3;
    localparam int unsigned LAT_MOV_RI = 2;
    localparam int unsigned LAT_LOAD   = 1;

    typedef enum logic [2:0] {
        S_WAIT, S_LOAD_A, S_LOAD_B, S_EXEC, S_WB, S_ERR
    } state_t;

    typedef enum logic [3:0] {
        OP_ALU_RR = 4'd0,
        OP_ALU_RI = 4'd1,
        OP_CMP_RR = 4'd2,
        OP_MOV_RI = 4'd3,
        OP_LOAD   = 4'd4
    } opcode_t;

    typedef struct packed {
        logic is_legal;
        logic needs_a;
        logic needs_b;
        logic writes_rd;
        logic sel_a;
        logic sel_b;
        logic wb_sel;
    } dec_t;

    typedef struct packed {
        logic                  waiting;
        logic                  done;
        logic                  err;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] w_addr;
        logic                  w_en;
        logic [REG_ADDR_W-1:0] r_addr;
        logic                  en_a;
        logic                  en_b;
        logic                  en_c;
        logic                  en_status;
        logic [1:0]            shift_op;
        logic                  sel_a;
        logic                  sel_b;
        logic [2:0]            alu_op;
    } ctrl_t;

    // Control pin values while sitting in state s with instruction iw
    function automatic ctrl_t ctrl_for(input state_t s, input logic [INSTR_W-1:0] iw,
                                       input dec_t d);
        ctrl_t c;
        c = '0;
        case (s)
            S_WAIT: c.waiting = 1'b1;
            S_LOAD_A: begin
                c.r_addr = iw[RN_HI:RN_LO];
                c.en_a   = 1'b1;
            end
            S_LOAD_B: begin
                c.r_addr = iw[RM_HI:RM_LO];
                c.en_b   = 1'b1;
            end
            S_EXEC: begin
                c.en_c      = 1'b1;
                c.en_status = 1'b1;
                c.alu_op    = iw[ALUOP_HI:ALUOP_LO];
                c.shift_op  = iw[SHOP_HI:SHOP_LO];
                c.sel_a     = d.sel_a;
                c.sel_b     = d.sel_b;
                c.done      = ~d.writes_rd;
            end
            S_WB: begin
                c.w_addr = iw[RD_HI:RD_LO];
                c.w_en   = 1'b1;
                c.wb_sel = d.wb_sel;
                c.done   = 1'b1;
            end
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Opcode classifier: legality, which phases an instruction needs and its mux selects.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ALU_RR: begin
                dec.is_legal  = 1'b1;
                dec.needs_a   = 1'b1;
                dec.needs_b   = 1'b1;
                dec.writes_rd = 1'b1;
            end
            OP_ALU_RI: begin
                dec.is_legal  = 1'b1;
                dec.needs_a   = 1'b1;
                dec.writes_rd = 1'b1;
                dec.sel_b     = 1'b1;
            end
            OP_CMP_RR: begin
                dec.is_legal = 1'b1;
                dec.needs_a  = 1'b1;
                dec.needs_b  = 1'b1;
            end
            OP_MOV_RI: begin
                dec.is_legal  = 1'b1;
                dec.writes_rd = 1'b1;
                dec.sel_a     = 1'b1;
                dec.sel_b     = 1'b1;
            end
            OP_LOAD: begin
                dec.is_legal  = 1'b1;
                dec.writes_rd = 1'b1;
                dec.wb_sel    = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer driving the register-file/shifter/ALU datapath control pins.
// Optional retired-instruction counter output enabled by DATAPATH_CTRL_PERF_EN.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
`ifdef DATAPATH_CTRL_PERF_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    output logic              waiting,
    output logic              done,
    output logic              err,
    output logic              wb_sel,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_en,
    output logic [ADDR_W-1:0] r_addr,
    output logic              en_A,
    output logic              en_B,
    output logic              en_C,
    output logic              en_status,
    output logic [1:0]        shift_op,
    output logic              sel_A,
    output logic              sel_B,
    output logic [2:0]        ALU_op
`ifdef DATAPATH_CTRL_PERF_EN
    , output logic [CNT_W-1:0] instr_count
`endif
);

    state_t              state;
    logic [INSTR_W-1:0]  instr_q;
    ctrl_t               ctrl;
    dec_t                dec_q;
    dec_t                dec_in;

    datapath_ctrl_decode u_dec_q  (.opcode(instr_q[OPC_HI:OPC_LO]), .dec(dec_q));
    datapath_ctrl_decode u_dec_in (.opcode(instr[OPC_HI:OPC_LO]),   .dec(dec_in));

    // State and control pins are registered together so pins always match the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_WAIT;
            instr_q <= '0;
            ctrl    <= ctrl_for(S_WAIT, '0, '0);
        end else begin
            case (state)
                S_WAIT: begin
                    if (start) begin
                        instr_q <= instr;
                        if (!dec_in.is_legal) begin
                            state <= S_ERR;
                            ctrl  <= ctrl_for(S_ERR, instr, dec_in);
                        end else if (dec_in.needs_a) begin
                            state <= S_LOAD_A;
                            ctrl  <= ctrl_for(S_LOAD_A, instr, dec_in);
                        end else if (dec_in.wb_sel) begin
                            state <= S_WB;
                            ctrl  <= ctrl_for(S_WB, instr, dec_in);
                        end else begin
                            state <= S_EXEC;
                            ctrl  <= ctrl_for(S_EXEC, instr, dec_in);
                        end
                    end
                end
                S_LOAD_A: begin
                    if (dec_q.needs_b) begin
                        state <= S_LOAD_B;
                        ctrl  <= ctrl_for(S_LOAD_B, instr_q, dec_q);
                    end else begin
                        state <= S_EXEC;
                        ctrl  <= ctrl_for(S_EXEC, instr_q, dec_q);
                    end
                end
                S_LOAD_B: begin
                    state <= S_EXEC;
                    ctrl  <= ctrl_for(S_EXEC, instr_q, dec_q);
                end
                S_EXEC: begin
                    if (dec_q.writes_rd) begin
                        state <= S_WB;
                        ctrl  <= ctrl_for(S_WB, instr_q, dec_q);
                    end else begin
                        state <= S_WAIT;
                        ctrl  <= ctrl_for(S_WAIT, instr_q, dec_q);
                    end
                end
                default: begin
                    state <= S_WAIT;
                    ctrl  <= ctrl_for(S_WAIT, instr_q, dec_q);
                end
            endcase
        end
    end

    assign waiting   = ctrl.waiting;
    assign done      = ctrl.done;
    assign err       = ctrl.err;
    assign wb_sel    = ctrl.wb_sel;
    assign w_addr    = ADDR_W'(ctrl.w_addr);
    assign w_en      = ctrl.w_en;
    assign r_addr    = ADDR_W'(ctrl.r_addr);
    assign en_A      = ctrl.en_a;
    assign en_B      = ctrl.en_b;
    assign en_C      = ctrl.en_c;
    assign en_status = ctrl.en_status;
    assign shift_op  = ctrl.shift_op;
    assign sel_A     = ctrl.sel_a;
    assign sel_B     = ctrl.sel_b;
    assign ALU_op    = ctrl.alu_op;

`ifdef DATAPATH_CTRL_PERF_EN
    logic [CNT_W-1:0] count_q;

    // Counts retired instructions; rejected opcodes never raise done
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (ctrl.done) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign instr_count = count_q;
`endif

endmodule
